// File: rtl/axis_length_checker.sv
// AXI-Stream packet length checker: forwards every beat through a 2-entry
// skid buffer and flags beats of runt or oversize packets on axis_o_error.
// Per-packet good/bad statistics are kept in saturating counters.
module axis_length_checker #(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int MIN_BEATS      = 1,
  parameter int MAX_BEATS      = 1518,
  parameter int COUNT_BITS     = 16
) (
  input  logic                      clk,
  input  logic                      sreset,
  input  logic                      axis_i_tvalid,
  output logic                      axis_i_tready,
  input  logic [8*AXIS_BYTES-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                      axis_i_tlast,
  input  logic                      axis_i_error,
  output logic                      axis_o_tvalid,
  input  logic                      axis_o_tready,
  output logic [8*AXIS_BYTES-1:0]   axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
  output logic                      axis_o_tlast,
  output logic                      axis_o_error,
  output logic [COUNT_BITS-1:0]     good_count,
  output logic [COUNT_BITS-1:0]     bad_count
);

  localparam int DW = 8 * AXIS_BYTES;
  localparam int PW = DW + AXIS_USER_BITS + 2;
  localparam int BW = $clog2(MAX_BEATS + 2);

  localparam logic [BW-1:0] MIN_B = BW'(MIN_BEATS);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BEATS);
  localparam logic [BW-1:0] SAT_B = BW'(MAX_BEATS + 1);

  localparam logic [1:0] ST_START    = 2'd0;
  localparam logic [1:0] ST_BODY     = 2'd1;
  localparam logic [1:0] ST_OVERSIZE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [BW-1:0] beat_num;
  logic [BW-1:0] cur_beat;
  logic          pkt_bad;
  logic          in_hs;
  logic          beat_err;
  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;
  logic [PW-1:0] skid_payload;
  logic          out_valid;
  logic          skid_valid;
  logic          in_ready;

  // Classify the beat currently offered on axis_i and pick the next state.
  always_comb begin
    in_hs      = axis_i_tvalid & in_ready;
    cur_beat   = (beat_num == SAT_B) ? SAT_B : beat_num + BW'(1);
    beat_err   = axis_i_error | (state == ST_OVERSIZE)
               | (axis_i_tlast & (cur_beat < MIN_B));
    in_payload = {axis_i_tlast, beat_err, axis_i_tuser, axis_i_tdata};
    if (axis_i_tlast)
      next_state = ST_START;
    else if (cur_beat >= MAX_B)
      next_state = ST_OVERSIZE;
    else
      next_state = ST_BODY;
  end

  // Packet tracking and statistics, advanced only on input handshakes.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state      <= ST_START;
      beat_num   <= '0;
      pkt_bad    <= 1'b0;
      good_count <= '0;
      bad_count  <= '0;
    end else if (in_hs) begin
      state    <= next_state;
      beat_num <= axis_i_tlast ? '0 : cur_beat;
      pkt_bad  <= axis_i_tlast ? 1'b0 : (pkt_bad | beat_err);
      if (axis_i_tlast) begin
        if (pkt_bad | beat_err) begin
          if (bad_count != '1) bad_count <= bad_count + COUNT_BITS'(1);
        end else begin
          if (good_count != '1) good_count <= good_count + COUNT_BITS'(1);
        end
      end
    end
  end

  // Skid buffer: the output register is refilled from the skid slot first;
  // tready is the registered "skid slot will be empty" condition, so a beat
  // accepted during an output stall always has somewhere to land.
  always_ff @(posedge clk) begin
    if (sreset) begin
      out_valid    <= 1'b0;
      out_payload  <= '0;
      skid_valid   <= 1'b0;
      skid_payload <= '0;
      in_ready     <= 1'b0;
    end else begin
      if (!out_valid || axis_o_tready) begin
        if (skid_valid) begin
          out_valid   <= 1'b1;
          out_payload <= skid_payload;
          skid_valid  <= 1'b0;
          in_ready    <= 1'b1;
        end else begin
          out_valid <= in_hs;
          if (in_hs) out_payload <= in_payload;
          in_ready <= 1'b1;
        end
      end else if (in_hs) begin
        skid_valid   <= 1'b1;
        skid_payload <= in_payload;
        in_ready     <= 1'b0;
      end else begin
        in_ready <= !skid_valid;
      end
    end
  end

  // Unpack the output register onto the master port.
  always_comb begin
    axis_i_tready = in_ready;
    axis_o_tvalid = out_valid;
    {axis_o_tlast, axis_o_error, axis_o_tuser, axis_o_tdata} = out_payload;
  end

endmodule

// File: doc/axis_length_checker.md
AXIS_LENGTH_CHECKER -- requirements
Module: axis_length_checker

Interface
REQ-001 The module SHALL have parameter AXIS_BYTES, default 1, meaning the tdata width in bytes (tdata is 8*AXIS_BYTES bits).
REQ-002 The module SHALL have parameter AXIS_USER_BITS, default 1, meaning the tuser width.
REQ-003 The module SHALL have parameter MIN_BEATS, default 1, meaning the minimum legal packet length in beats (range 1..MAX_BEATS).
REQ-004 The module SHALL have parameter MAX_BEATS, default 1518, meaning the maximum legal packet length in beats.
REQ-005 The module SHALL have parameter COUNT_BITS, default 16, meaning the width of the statistics counters.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port sreset, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have ports axis_i_tvalid/tready/tlast (1 bit each), axis_i_tdata (8*AXIS_BYTES), axis_i_tuser (AXIS_USER_BITS): the AXI-Stream slave; tready is an output.
REQ-009 The module SHALL have port axis_i_error, input, 1 bit: an upstream per-beat error, qualified by an axis_i handshake.
REQ-010 The module SHALL have ports axis_o_tvalid/tready/tlast/tdata/tuser, with widths as in REQ-008: the AXI-Stream master; tready is an input.
REQ-011 The module SHALL have port axis_o_error, output, 1 bit: a per-beat error flag, valid with axis_o_tvalid and suited to feeding an error-filter drop input.
REQ-012 The module SHALL have ports good_count and bad_count, outputs, COUNT_BITS each: packet statistics.

Function
REQ-013 The module SHALL pass every input beat to the output unmodified and in order; it SHALL NOT drop, insert or truncate beats.
REQ-014 The module SHALL register the data path through a 2-entry skid buffer: 1-cycle latency, one beat per cycle sustained, and axis_i_tready driven from a register only.
REQ-015 The module SHALL keep axis_o_tvalid and all axis_o payload signals stable while axis_o_tvalid=1 and axis_o_tready=0.
REQ-016 The module SHALL number beats from 1 using beat_num, which counts input handshakes within a packet, saturates at MAX_BEATS+1, and is sized $clog2(MAX_BEATS+2).
REQ-017 The module SHALL use a state machine with states START (awaiting beat 1), BODY (beat_num <= MAX_BEATS) and OVERSIZE (limit exceeded); transitions occur only on axis_i handshakes.
REQ-018 The module SHALL make these transitions: START->BODY on a non-last beat; BODY->OVERSIZE when beat MAX_BEATS is accepted without tlast; any state->START on an accepted tlast.
REQ-019 The module SHALL set the output beat's error = axis_i_error OR (beat_num > MAX_BEATS) OR (tlast AND beat_num < MIN_BEATS).
REQ-020 The module SHALL flag every beat after MAX_BEATS while in OVERSIZE, not only the first.
REQ-021 The module SHALL treat a single-beat packet (tlast on beat 1) as a START->START transition, with a short error if MIN_BEATS > 1.
REQ-022 The module SHALL hold a per-packet latch pkt_bad, set by any flagged beat and cleared on the accepted tlast.
REQ-023 On an accepted tlast, the module SHALL increment bad_count if pkt_bad OR the current beat's error is set, and otherwise increment good_count.
REQ-024 The module SHALL saturate both counters at 2^COUNT_BITS-1; they SHALL NOT wrap.
REQ-025 The module SHALL update counters on the input handshake, so they lead the output beat by the buffer latency.
REQ-026 The module SHALL hold state while axis_i_tvalid=0 mid-packet; input gaps and output stalls SHALL NOT alter counts or flags.

Reset
REQ-027 While sreset=1, the module SHALL hold axis_i_tready=0, axis_o_tvalid=0, axis_o_error=0, good_count=0, bad_count=0, state=START, beat_num=0, pkt_bad=0, and empty the skid buffer.
REQ-028 A reset asserted mid-packet SHALL discard buffered beats; the next input beat after reset is beat 1 of a new packet.
REQ-029 The module SHALL raise axis_i_tready on the first cycle after sreset deasserts.

Verification
REQ-030 Verification SHALL cover: MIN=2, MAX=4; 3-beat packet, tready=1 -> 3 output beats 1 cycle later, error=0 on all, good_count=1.
REQ-031 Verification SHALL cover: MAX=4; 6-beat packet -> beats 5 and 6 error=1, beats 1-4 error=0, bad_count=1, all 6 beats delivered.
REQ-032 Verification SHALL cover: MIN=2; 1-beat packet followed by a 4-beat packet -> first beat error=1, bad=1; second packet clean, good=1.
REQ-033 Verification SHALL cover: axis_i_error pulsed on beat 2 of 3 -> only beat 2 flagged; bad_count increments at tlast.
REQ-034 Verification SHALL cover: random axis_o_tready (50%) and axis_i_tvalid gaps -> output stream identical to input, no beat lost or duplicated, payload stable under stall.
REQ-035 Verification SHALL cover: COUNT_BITS=2 with 5 good packets -> good_count sticks at 3; sreset asserted mid-packet -> outputs per REQ-027, next packet counted fresh.
